div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle divide sequencer beside the EX stage. Serves DIV/DIVU.
- EX raises a start request with two operands. The block holds EX stalled through a radix-2 restoring-division FSM.
- It returns {remainder, quotient}, which EX writes to HI/LO.
- It also supports annul (pipeline flush) mid-operation.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- div_i_start  in  1  level request from EX. Held high until div_o_ready is seen, then dropped.
- div_i_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- div_i_op0  in  WIDTH  dividend (rs)
- div_i_op1  in  WIDTH  divisor (rt)
- div_i_annul  in  1  flush. Abort any operation in progress.
- div_o_result  out  2*WIDTH  [2W-1:W] remainder (to HI), [W-1:0] quotient (to LO)
- div_o_ready  out  1  result valid
- div_o_stall_req  out  1  request to stall IF/ID/EX

Behaviour:
- All state is updated on the clk rising edge.
- Reset: rst=1 at an edge forces the following, regardless of state:
  - state IDLE, counter 0
  - div_o_result 0, div_o_ready 0
  - internal dividend/divisor/partial-remainder registers 0
- States: IDLE, BYZERO, BUSY, DONE.
- IDLE:
  - If start=1, annul=0 and op1==0, go to BYZERO.
  - If start=1, annul=0 and op1!=0, go to BUSY. Latch operands:
    - Signed mode: latch absolute values, and record sign flags q_neg = op0[W-1]^op1[W-1] and r_neg = op0[W-1].
    - Unsigned mode: latch op0/op1 as is, both flags 0.
    - Partial remainder 0, counter 0.
  - Otherwise stay in IDLE.
- BYZERO: next edge registers result 0 and goes to DONE. There is no trap.
- BUSY:
  - Each edge performs one iteration:
    - Shift {rem, dividend} left by 1.
    - Compute trial = rem_shifted - divisor, W+1 bits.
    - If trial is non-negative, rem = trial[W-1:0] and quotient LSB = 1. Otherwise keep rem and quotient LSB = 0.
  - Counter increments on each iteration.
  - The edge on which counter==W-1 performs the final iteration and registers the sign-corrected result:
    - quotient negated (two's complement) if q_neg
    - remainder negated if r_neg
  - That edge also moves the state to DONE.
- DONE:
  - div_o_ready=1 and div_o_result is stable.
  - Leave to IDLE on the first edge where start=0. Result register holds its value; ready drops.
  - While start stays 1, remain in DONE. There is no auto-restart.
- Latency: start first high in cycle 0 (IDLE) gives BUSY in cycles 1..W and ready=1 in cycle W+1 (cycle 33 for W=32). Divide-by-zero gives ready in cycle 2.
- div_o_stall_req is combinational:
  - 1 when start=1 and state!=DONE and annul=0.
  - 0 otherwise, including in DONE, so EX advances in the ready cycle.
- Annul:
  - annul=1 at an edge in BUSY or BYZERO returns to IDLE with ready staying 0 and result unchanged.
  - In IDLE, annul blocks acceptance.
  - In DONE, annul forces IDLE.
  - rst has priority over annul.
- Operand changes while BUSY are ignored, since operands were latched at acceptance.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the natural wrap; no overflow flag is produced.
- Width rules:
  - Absolute value of the most negative value is taken as an unsigned W-bit magnitude, which is correct.
  - Subtraction is W+1 bits wide; the borrow bit decides the quotient bit.

Test Plan:
- Unsigned: signed=0, op0=100, op1=7, start held.
  - stall_req=1 in cycles 0..32.
  - Cycle 33: ready=1, result={32'd2, 32'd14}, stall_req=0.
  - Drop start: ready=0 next cycle.
- Signed:
  - op0=-7 (0xFFFFFFF9), op1=2 gives quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
  - op0=7, op1=-2 gives quotient -3, remainder 1.
  - 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
- Divide by zero: op1=0 with start gives ready in cycle 2 and result 0. Unsigned 0xFFFFFFFF/1 gives {0, 0xFFFFFFFF} at cycle 33.
- Annul: start at cycle 0, annul=1 in cycle 10.
  - Cycle 11: IDLE, ready=0, stall_req=0.
  - A new start in cycle 12 with 9/3 gives {0, 3} in cycle 45.
- Reset mid-op: rst=1 in cycle 20 of a BUSY divide.
  - Next cycle: ready=0, result=0, IDLE.
  - With start still 1 after rst drops, a fresh operation begins; first ready is 33 cycles later.
- Hold in DONE: keep start=1 for 5 cycles after ready. Ready and result stay constant, no restart, and stall_req stays 0 throughout.

Source files
------------

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
//   Multi-cycle radix-2 restoring divide sequencer that sits beside the EX
//   stage and serves DIV / DIVU. EX holds a start request with two operands.
//   The block stalls the front of the pipeline while it iterates, then
//   presents {remainder, quotient} for the HI/LO write. A flush (annul)
//   abandons an operation in progress.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous reset, active-high
//   div_i_start     level request from EX, held until ready is seen
//   div_i_signed    1 = DIV (two's complement), 0 = DIVU
//   div_i_op0       dividend (rs)
//   div_i_op1       divisor (rt)
//   div_i_annul     pipeline flush, aborts any operation in progress
//   div_o_result    [2W-1:W] remainder (HI), [W-1:0] quotient (LO)
//   div_o_ready     result valid (high while in DONE)
//   div_o_stall_req combinational stall request to IF/ID/EX
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_i_start,
  input  logic               div_i_signed,
  input  logic [WIDTH-1:0]   div_i_op0,
  input  logic [WIDTH-1:0]   div_i_op1,
  input  logic               div_i_annul,
  output logic [2*WIDTH-1:0] div_o_result,
  output logic               div_o_ready,
  output logic               div_o_stall_req
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] next_quot;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] fixed_quot;
  logic [WIDTH-1:0] fixed_rem;
  logic [WIDTH-1:0] abs_op0;
  logic [WIDTH-1:0] abs_op1;

  // One restoring-division step. The quotient bits shift into the dividend
  // register as the dividend bits shift out into the partial remainder.
  // Bit WIDTH of the (WIDTH+1)-bit trial is the borrow: set means the
  // divisor did not fit and the shifted remainder is kept.
  always_comb begin
    shifted    = {rem, dividend[WIDTH-1]};
    trial      = shifted - {1'b0, divisor};
    next_quot  = {dividend[WIDTH-2:0], ~trial[WIDTH]};
    next_rem   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    fixed_quot = q_neg ? -next_quot : next_quot;
    fixed_rem  = r_neg ? -next_rem : next_rem;
  end

  // Magnitudes for signed mode. The most negative value negates to itself,
  // which read as an unsigned magnitude is exactly right.
  always_comb begin
    abs_op0 = (div_i_signed && div_i_op0[WIDTH-1]) ? -div_i_op0 : div_i_op0;
    abs_op1 = (div_i_signed && div_i_op1[WIDTH-1]) ? -div_i_op1 : div_i_op1;
  end

  // Sequencer. Annul out of BUSY/BYZERO leaves the result register alone so
  // HI/LO observers keep the last completed value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      dividend     <= '0;
      divisor      <= '0;
      rem          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_i_start && !div_i_annul) begin
            if (div_i_op1 == '0) begin
              state <= BYZERO;
            end else begin
              state    <= BUSY;
              dividend <= abs_op0;
              divisor  <= abs_op1;
              rem      <= '0;
              counter  <= '0;
              q_neg    <= div_i_signed & (div_i_op0[WIDTH-1] ^ div_i_op1[WIDTH-1]);
              r_neg    <= div_i_signed & div_i_op0[WIDTH-1];
            end
          end
        end
        BYZERO: begin
          if (div_i_annul) begin
            state <= IDLE;
          end else begin
            div_o_result <= '0;
            state        <= DONE;
          end
        end
        BUSY: begin
          if (div_i_annul) begin
            state <= IDLE;
          end else begin
            dividend <= next_quot;
            rem      <= next_rem;
            counter  <= counter + CW'(1);
            if (counter == CW'(WIDTH - 1)) begin
              div_o_result <= {fixed_rem, fixed_quot};
              state        <= DONE;
            end
          end
        end
        DONE: begin
          if (div_i_annul || !div_i_start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall drops in DONE so EX advances in the same cycle it sees ready.
  always_comb begin
    div_o_ready     = (state == DONE);
    div_o_stall_req = div_i_start && (state != DONE) && !div_i_annul;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
//   Self-checking bench for div_ctrl (WIDTH = 32). Directed vectors with
//   hand-computed results are pushed into a scoreboard queue when issued; a
//   monitor pops and compares on each rising edge of div_o_ready. The
//   stimulus side checks latency, stall behaviour, annul and reset.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_i_start;
  logic        div_i_signed;
  logic [31:0] div_i_op0;
  logic [31:0] div_i_op1;
  logic        div_i_annul;
  logic [63:0] div_o_result;
  logic        div_o_ready;
  logic        div_o_stall_req;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          t0;
  logic [63:0] sb[$];

  div_ctrl #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_i_start    (div_i_start),
    .div_i_signed   (div_i_signed),
    .div_i_op0      (div_i_op0),
    .div_i_op1      (div_i_op1),
    .div_i_annul    (div_i_annul),
    .div_o_result   (div_o_result),
    .div_o_ready    (div_o_ready),
    .div_o_stall_req(div_o_stall_req)
  );

  // Free-running clock and a cycle counter that steps on each rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point used by both stimulus and monitor.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new assertion of ready must deliver the oldest expected
  // result still waiting in the scoreboard.
  initial begin : monitor
    logic        ready_q;
    logic [63:0] exp;
    ready_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_q = 1'b0;
      end else begin
        if (div_o_ready && !ready_q) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_ready", 64'd1, 64'd0);
          end else begin
            exp = sb.pop_front();
            checkOutput("result", div_o_result, exp);
          end
        end
        ready_q = div_o_ready;
      end
    end
  end

  // Raises start with the given operands in a fresh cycle (cycle 0 = t0)
  // and optionally queues the expected result.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp,
                               input bit push);
    @(posedge clk);
    #1;
    div_i_start  = 1'b1;
    div_i_signed = sgn;
    div_i_op0    = a;
    div_i_op1    = b;
    t0           = cyc;
    if (push) sb.push_back(exp);
  endtask

  // Waits (bounded) for ready, checking stall is held every cycle before it.
  // The operands are scrambled once the request is accepted to show they
  // were latched. Returns at the negedge of the ready cycle.
  task automatic waitReady(input int lat);
    bit stall_ok;
    bit got;
    stall_ok = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (div_o_ready) begin
        got = 1'b1;
      end else begin
        if (!div_o_stall_req) stall_ok = 1'b0;
        if (i == 1) begin
          div_i_op0 = ~div_i_op0;
          div_i_op1 = ~div_i_op1;
        end
      end
    end
    checkOutput("ready_seen", 64'(got), 64'd1);
    checkOutput("stall_before_ready", 64'(stall_ok), 64'd1);
    checkOutput("latency", 64'(cyc - t0), 64'(lat));
    checkOutput("stall_in_ready", 64'(div_o_stall_req), 64'd0);
  endtask

  // Full transaction: issue, wait, optionally hold start in DONE, then drop
  // start in the ready cycle and confirm ready falls while result holds.
  task automatic runDiv(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int lat, input int hold);
    applyStimulus(sgn, a, b, exp, 1'b1);
    waitReady(lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_ready", 64'(div_o_ready), 64'd1);
      checkOutput("hold_result", div_o_result, exp);
      checkOutput("hold_stall", 64'(div_o_stall_req), 64'd0);
    end
    div_i_start = 1'b0;
    @(negedge clk);
    checkOutput("ready_drop", 64'(div_o_ready), 64'd0);
    checkOutput("result_kept", div_o_result, exp);
  endtask

  initial begin : stimulus
    n_checks     = 0;
    n_fail       = 0;
    t0           = 0;
    rst          = 1'b1;
    div_i_start  = 1'b0;
    div_i_signed = 1'b0;
    div_i_op0    = '0;
    div_i_op1    = '0;
    div_i_annul  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 64'(div_o_ready), 64'd0);
    checkOutput("reset_result", div_o_result, 64'd0);
    checkOutput("reset_stall", 64'(div_o_stall_req), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] divide by zero");
    runDiv(1'b0, 32'd5,         32'd0, 64'd0, 2, 0);
    runDiv(1'b1, 32'h1234_5678, 32'd0, 64'd0, 2, 0);

    $display("[TB] unsigned and signed vectors");
    runDiv(1'b0, 32'd100,       32'd7,          {32'd2, 32'd14}, 33, 0);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    runDiv(1'b1, 32'd7,         32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}, 33, 0);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  {32'd0, 32'h8000_0000}, 33, 0);
    runDiv(1'b0, 32'h8000_0000, 32'h8000_0001,  {32'h8000_0000, 32'd0}, 33, 0);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  {32'd0, 32'd1}, 33, 0);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'd1,          {32'd0, 32'hFFFF_FFFF}, 33, 0);

    // Annul in cycle 10 of a BUSY divide; the result register must still
    // hold the previous quotient/remainder.
    $display("[TB] annul mid-operation");
    applyStimulus(1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 div_i_annul = 1'b1;
    @(posedge clk);
    #1;
    div_i_annul = 1'b0;
    div_i_start = 1'b0;
    @(negedge clk);
    checkOutput("annul_cycle", 64'(cyc - t0), 64'd11);
    checkOutput("annul_ready", 64'(div_o_ready), 64'd0);
    checkOutput("annul_stall", 64'(div_o_stall_req), 64'd0);
    checkOutput("annul_result_kept", div_o_result, {32'd0, 32'hFFFF_FFFF});
    runDiv(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    $display("[TB] hold in DONE");
    runDiv(1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 33, 5);

    // Reset in cycle 20 of a BUSY divide with start still held; a fresh
    // operation must follow once reset drops.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h10, 64'd0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 64'(div_o_ready), 64'd0);
    checkOutput("rst_result", div_o_result, 64'd0);
    t0 = cyc;
    sb.push_back({32'hF, 32'h0DEA_DBEE});
    waitReady(33);
    div_i_start = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready_drop", 64'(div_o_ready), 64'd0);

    // Annul while in DONE with start still high forces IDLE.
    $display("[TB] annul in DONE");
    applyStimulus(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 1'b1);
    waitReady(33);
    div_i_annul = 1'b1;
    @(negedge clk);
    checkOutput("done_annul_ready", 64'(div_o_ready), 64'd0);
    checkOutput("done_annul_stall", 64'(div_o_stall_req), 64'd0);
    checkOutput("done_annul_result", div_o_result, {32'd2, 32'd3});
    div_i_annul = 1'b0;
    div_i_start = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
